// File: rtl/aes_enc_sched.sv
// Shares one external combinational AES_Encrypt core between two requesters:
// round-robin accept, registered operands, fixed settle wait, registered result.
module aes_enc_sched #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_plaintext,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_plaintext,
  input  logic [127:0] req1_key,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp_data,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_ciphertext,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [127:0]  pt_q, pt_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  rsp_q, rsp_d;
  logic          grant0, grant1;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; valid and its payload must stay put until that edge.
  // Ready is only raised in IDLE, and only for the arbitration winner.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    pt_d         = pt_q;
    key_d        = key_q;
    rsp_d        = rsp_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = SETTLE;
          cnt_d        = CNT_INIT;
          owner_d      = grant1;
          last_grant_d = grant1;
          pt_d         = grant1 ? req1_plaintext : req0_plaintext;
          key_d        = grant1 ? req1_key : req0_key;
        end
      end
      SETTLE: begin
        // Capture on the edge where the counter has run out, SETTLE_CYCLES edges after accept.
        if (cnt_q == '0) begin
          rsp_d   = core_ciphertext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pt_q         <= '0;
      key_q        <= '0;
      rsp_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      pt_q         <= pt_d;
      key_q        <= key_d;
      rsp_q        <= rsp_d;
    end
  end

  assign req0_ready     = grant0;
  assign req1_ready     = grant1;
  assign rsp0_valid     = (state_q == RESP) && !owner_q;
  assign rsp1_valid     = (state_q == RESP) && owner_q;
  assign rsp_data       = rsp_q;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aes_enc_sched.sv
// Bench for aes_enc_sched: AES-128 reference model drives the core port,
// scoreboard queue checks every response; a second instance uses SETTLE_CYCLES=1.
module tb_aes_enc_sched;

  localparam int SETTLE = 4;
  localparam logic [127:0] T1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] T2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] T2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] k[16];
    logic [7:0] tmp[4];
    logic [7:0] rc;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      tmp[0] = sbox(k[13]) ^ rc;
      tmp[1] = sbox(k[14]);
      tmp[2] = sbox(k[15]);
      tmp[3] = sbox(k[12]);
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [127:0] rsp_data, core_plaintext, core_key, core_ciphertext;
  logic         busy;
  logic [1:0]   dbg_state;

  assign core_ciphertext = aes_enc(core_plaintext, core_key);

  aes_enc_sched #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_plaintext(req0_plaintext), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_plaintext(req1_plaintext), .req1_key(req1_key),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_ciphertext(core_ciphertext), .busy(busy), .dbg_state_o(dbg_state)
  );

  logic         s1_req0_valid, s1_req0_ready, s1_req1_ready;
  logic         s1_rsp0_valid, s1_rsp1_valid, s1_busy;
  logic [127:0] s1_rsp_data, s1_core_pt, s1_core_key, s1_core_ct;
  logic [1:0]   s1_dbg;

  assign s1_core_ct = aes_enc(s1_core_pt, s1_core_key);

  aes_enc_sched #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready),
    .req0_plaintext(T2_PT), .req0_key(T2_KEY),
    .req1_valid(1'b0), .req1_ready(s1_req1_ready),
    .req1_plaintext(128'd0), .req1_key(128'd0),
    .rsp0_valid(s1_rsp0_valid), .rsp0_ready(1'b1),
    .rsp1_valid(s1_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_data(s1_rsp_data), .core_plaintext(s1_core_pt), .core_key(s1_core_key),
    .core_ciphertext(s1_core_ct), .busy(s1_busy), .dbg_state_o(s1_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rsp_prev = 1'b0;
  bit s1_prev = 1'b0;
  logic [127:0] exp_q[$];
  int own_q[$];
  int grant_q[$];
  int acc_q[$];
  int s1_acc_q[$];
  int s1_rsp_q[$];
  logic [127:0] s1_dat_q[$];
  logic [127:0] last_rsp1 = '0;
  logic [127:0] e;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_prev = 1'b0;
    end else begin
      if (req0_ready || req1_ready) check("ready_onehot", req0_ready & req1_ready, 0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back(aes_enc(req0_plaintext, req0_key));
        own_q.push_back(0); grant_q.push_back(0); acc_q.push_back(cyc + 1); last_acc = cyc + 1;
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(aes_enc(req1_plaintext, req1_key));
        own_q.push_back(1); grant_q.push_back(1); acc_q.push_back(cyc + 1); last_acc = cyc + 1;
      end
      if (rsp0_valid || rsp1_valid) begin
        if (!rsp_prev) check("rsp_latency", cyc - last_acc, SETTLE);
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          if (exp_q.size() == 0) begin
            check("rsp_with_empty_queue", {rsp0_valid, rsp1_valid}, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_owner", rsp1_valid, own_q.pop_front());
            check("rsp_valid_onehot", rsp0_valid & rsp1_valid, 0);
            check("rsp_data", rsp_data, e);
            if (rsp1_valid) last_rsp1 = rsp_data;
          end
        end
      end
      rsp_prev = rsp0_valid || rsp1_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      s1_prev = 1'b0;
    end else begin
      if (s1_req0_valid && s1_req0_ready) s1_acc_q.push_back(cyc + 1);
      if (s1_rsp0_valid && !s1_prev) begin
        s1_rsp_q.push_back(cyc);
        s1_dat_q.push_back(s1_rsp_data);
      end
      s1_prev = s1_rsp0_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int id);
    for (int i = 0; i < 200; i++) begin
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", (id == 0) ? req0_ready : req1_ready, 1);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drive_job(input int id, input logic [127:0] pt, input logic [127:0] key);
    if (id == 0) begin
      req0_plaintext = pt; req0_key = key; req0_valid = 1'b1;
    end else begin
      req1_plaintext = pt; req1_key = key; req1_valid = 1'b1;
    end
    #1;
    wait_accept(id);
  endtask

  task automatic wait_rsp(input int id);
    for (int i = 0; i < 200; i++) begin
      if ((id == 0) ? rsp0_valid : rsp1_valid) return;
      @(negedge clk);
    end
    check("rsp_timeout", (id == 0) ? rsp0_valid : rsp1_valid, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      @(negedge clk);
    end
    check("drain_timeout", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete(); own_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp0_valid"}, rsp0_valid, 0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 0);
    check({tag, "_core_pt"}, core_plaintext, 0);
    check({tag, "_core_key"}, core_key, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [127:0] a3, k3, pa, ka;
  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_plaintext = '0; req0_key = '0; req1_plaintext = '0; req1_key = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    s1_req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single job on requester 0
    drive_job(0, T1_PT, T1_KEY);
    wait_rsp(0);
    check("t1_data", rsp_data, T1_CT);
    check("t1_rsp1_low", rsp1_valid, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_idle", busy, 0);
    check("t1_rsp_drop", rsp0_valid, 0);
    @(posedge clk); #1;

    // T2: both valid out of reset, held for four grants
    do_reset();
    grant_q.delete(); acc_q.delete();
    req0_plaintext = T1_PT; req0_key = T1_KEY;
    req1_plaintext = T2_PT; req1_key = T2_KEY;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (grant_q.size() >= 4) break;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (grant_q.size() > i) check($sformatf("t2_grant%0d", i), grant_q[i], i % 2);
    for (int i = 0; i < 3; i++)
      if (acc_q.size() > i + 1) check($sformatf("t2_spacing%0d", i), acc_q[i+1] - acc_q[i], SETTLE + 2);
    wait_drain();
    check("t2_rsp1_data", last_rsp1, T2_CT);
    @(posedge clk); #1;

    // T3: response backpressure with both requesters waiting
    rsp0_ready = 1'b0;
    a3 = {$urandom, $urandom, $urandom, $urandom};
    k3 = {$urandom, $urandom, $urandom, $urandom};
    drive_job(0, a3, k3);
    req0_plaintext = {$urandom, $urandom, $urandom, $urandom}; req0_valid = 1'b1;
    req1_plaintext = {$urandom, $urandom, $urandom, $urandom}; req1_valid = 1'b1;
    wait_rsp(0);
    for (int i = 0; i < 20; i++) begin
      check("t3_rsp0_valid", rsp0_valid, 1);
      check("t3_rsp_data", rsp_data, aes_enc(a3, k3));
      check("t3_req0_ready", req0_ready, 0);
      check("t3_req1_ready", req1_ready, 0);
      check("t3_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_rsp_drop", rsp0_valid, 0);
    check("t3_idle", busy, 0);
    check("t3_fair_req1", req1_ready, 1);
    wait_accept(1);
    wait_accept(0);
    wait_drain();
    @(posedge clk); #1;

    // T5: reset during SETTLE, then during RESP
    drive_job(0, {$urandom, $urandom, $urandom, $urandom}, T1_KEY);
    repeat (2) @(posedge clk);
    #1;
    check("t5a_in_settle", dbg_state, 1);
    rst_n = 1'b0; exp_q.delete(); own_q.delete();
    #1;
    check_reset_outputs("t5a");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5a_no_stale", rsp0_valid | rsp1_valid, 0);
    check("t5a_idle", busy, 0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    drive_job(0, T2_PT, T2_KEY);
    wait_rsp(0);
    @(posedge clk); #1;
    rst_n = 1'b0; exp_q.delete(); own_q.delete();
    #1;
    check_reset_outputs("t5b");
    @(posedge clk); #1;
    rst_n = 1'b1; rsp0_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("t5b_no_stale", rsp0_valid | rsp1_valid, 0);
    @(posedge clk); #1;
    drive_job(0, T1_PT, T1_KEY);
    wait_rsp(0);
    check("t5_after_data", rsp_data, T1_CT);
    wait_drain();
    @(posedge clk); #1;

    // T6: operands are held after the handshake
    pa = {$urandom, $urandom, $urandom, $urandom};
    ka = {$urandom, $urandom, $urandom, $urandom};
    drive_job(0, pa, ka);
    req0_plaintext = ~pa; req0_key = ~ka;
    @(negedge clk);
    check("t6_core_pt", core_plaintext, pa);
    check("t6_core_key", core_key, ka);
    wait_rsp(0);
    check("t6_core_pt_resp", core_plaintext, pa);
    check("t6_data", rsp_data, aes_enc(pa, ka));
    wait_drain();
    @(posedge clk); #1;

    // random jobs on either requester
    for (int n = 0; n < 6; n++) begin
      drive_job($urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom});
      wait_drain();
      @(posedge clk); #1;
    end

    // T4: SETTLE_CYCLES=1 instance, back-to-back with ready tied high
    s1_req0_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 s1_req0_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_accepts", s1_acc_q.size() >= 3, 1);
    check("t4_rsp_count", s1_rsp_q.size(), s1_acc_q.size());
    for (int i = 0; i + 1 < s1_acc_q.size(); i++)
      check($sformatf("t4_spacing%0d", i), s1_acc_q[i+1] - s1_acc_q[i], 3);
    for (int i = 0; i < s1_rsp_q.size(); i++) begin
      if (s1_acc_q.size() > i) check($sformatf("t4_latency%0d", i), s1_rsp_q[i] - s1_acc_q[i], 1);
      check($sformatf("t4_data%0d", i), s1_dat_q[i], T2_CT);
    end
    check("t4_idle", s1_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
